// File: rtl/tmds_link_encoder.sv
// tmds_link_encoder
//
// Multi-lane TMDS symbol encoder for the pixel-clock video output path.
// Every lane produces one 10-bit symbol per clock. The symbol class comes
// from I_mode: control codes, DVI 8b/10b video with DC balance, TERC4
// data-island symbols, or guard bands. The pipeline has two register
// stages, so a symbol appears on O_tmds two clocks after its inputs are
// sampled.
//
// Ports
//   I_clk         pixel clock, rising edge
//   I_rst         asynchronous active-high reset
//   I_mode        00 control, 01 video, 10 TERC4 data island, 11 guard band
//   I_guard_type  when I_mode=11: 0 video guard, 1 data-island guard
//   I_video_data  8 bits per lane, pixel byte
//   I_ctrl_data   2 bits per lane, {C1,C0}; lane 0 carries {VS,HS}
//   I_aux_data    4 bits per lane, TERC4 nibble
//   O_tmds        10 bits per lane; lane k at [10k+9:10k]; bit 0 goes out first
//   O_valid       goes high once real post-reset data reaches O_tmds
//
// Flow control: the stream has no backpressure. O_valid is a plain status
// flag, not a handshake; once it rises, every clock delivers a symbol on
// every lane until the next reset.
module tmds_link_encoder #(
  parameter int N_CH = 3
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic [1:0]          I_mode,
  input  logic                I_guard_type,
  input  logic [8*N_CH-1:0]   I_video_data,
  input  logic [2*N_CH-1:0]   I_ctrl_data,
  input  logic [4*N_CH-1:0]   I_aux_data,
  output logic [10*N_CH-1:0]  O_tmds,
  output logic                O_valid
);

  localparam logic [1:0] MODE_CTRL  = 2'b00;
  localparam logic [1:0] MODE_TERC4 = 2'b10;
  localparam logic [1:0] MODE_GUARD = 2'b11;

  // Symbol constants, written bit 9 first.
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] n);
    logic [9:0] s;
    case (n)
      4'd0:    s = 10'b1010011100;
      4'd1:    s = 10'b1001100011;
      4'd2:    s = 10'b1011100100;
      4'd3:    s = 10'b1011100010;
      4'd4:    s = 10'b0101110001;
      4'd5:    s = 10'b0100011110;
      4'd6:    s = 10'b0110001110;
      4'd7:    s = 10'b0100111100;
      4'd8:    s = 10'b1011001100;
      4'd9:    s = 10'b0100111001;
      4'd10:   s = 10'b0110011100;
      4'd11:   s = 10'b1011000110;
      4'd12:   s = 10'b1010001110;
      4'd13:   s = 10'b1001110001;
      4'd14:   s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Stage-1 registers shared by all lanes. Mode and guard type travel with
  // the payload so a mode change lands on exactly the matching symbol.
  logic [1:0]         r_mode;
  logic               r_guard;
  logic [4*N_CH-1:0]  r_aux;
  logic [2*N_CH-1:0]  r_ctrl;
  logic [1:0]         r_vld;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_mode  <= MODE_CTRL;
      r_guard <= 1'b0;
      r_aux   <= '0;
      r_ctrl  <= '0;
      r_vld   <= 2'b00;
    end else begin
      r_mode  <= I_mode;
      r_guard <= I_guard_type;
      r_aux   <= I_aux_data;
      r_ctrl  <= I_ctrl_data;
      // Valid follows the data through both stages.
      r_vld   <= {r_vld[0], 1'b1};
    end
  end

  assign O_valid = r_vld[1];

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    localparam logic [9:0] VID_GUARD = (k % 2 == 0) ? GUARD_A : GUARD_B;

    logic [7:0]        w_d;
    logic [3:0]        w_n1_d;
    logic              w_xnor;
    logic [8:0]        w_qm;
    logic [8:0]        r_qm;
    logic [3:0]        w_n1_q;
    logic signed [4:0] w_diff;
    logic [9:0]        w_sym;
    logic signed [4:0] w_cnt_nxt;
    logic [9:0]        r_sym;
    logic signed [4:0] r_cnt;

    assign w_d = I_video_data[8*k +: 8];

    // ---------------- Stage 1: transition minimisation ----------------
    always_comb begin
      w_n1_d = 4'd0;
      for (int i = 0; i < 8; i++) w_n1_d = w_n1_d + {3'b000, w_d[i]};
    end

    assign w_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !w_d[0]);

    always_comb begin
      logic [8:0] v_qm;
      v_qm    = '0;
      v_qm[0] = w_d[0];
      for (int i = 1; i < 8; i++)
        v_qm[i] = w_xnor ? ~(v_qm[i-1] ^ w_d[i]) : (v_qm[i-1] ^ w_d[i]);
      // q_m[8] flags XOR coding so the receiver can undo it.
      v_qm[8] = ~w_xnor;
      w_qm    = v_qm;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) r_qm <= '0;
      else       r_qm <= w_qm;
    end

    // ---------------- Stage 2: DC balance and symbol select ----------------
    always_comb begin
      w_n1_q = 4'd0;
      for (int i = 0; i < 8; i++) w_n1_q = w_n1_q + {3'b000, r_qm[i]};
    end

    // n1 - n0 = 2*n1 - 8; the 5-bit wrap gives the signed result directly.
    assign w_diff = $signed({w_n1_q, 1'b0} - 5'd8);

    always_comb begin
      w_sym     = CTRL_00;
      w_cnt_nxt = 5'sd0;      // every non-video symbol clears the disparity
      case (r_mode)
        MODE_CTRL:  w_sym = ctrl_sym(r_ctrl[2*k +: 2]);
        MODE_TERC4: w_sym = terc4_sym(r_aux[4*k +: 4]);
        MODE_GUARD: begin
          if (!r_guard)   w_sym = VID_GUARD;
          else if (k == 0) w_sym = terc4_sym({2'b11, r_ctrl[1:0]});
          else            w_sym = GUARD_B;
        end
        default: begin
          if (r_cnt == 5'sd0 || w_n1_q == 4'd4) begin
            w_sym     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
          end else if ((!r_cnt[4] && w_n1_q > 4'd4) || (r_cnt[4] && w_n1_q < 4'd4)) begin
            // Disparity and word lean the same way: send inverted.
            w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
          end else begin
            w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_nxt = r_cnt - (r_qm[8] ? 5'sd0 : 5'sd2) + w_diff;
          end
        end
      endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
        r_sym <= CTRL_00;
        r_cnt <= 5'sd0;
      end else begin
        r_sym <= w_sym;
        r_cnt <= w_cnt_nxt;
      end
    end

    assign O_tmds[10*k +: 10] = r_sym;
  end

endmodule
